alu_mul_seq: RTL and testbench

//  Multi-cycle sequencer for the execute-stage multiply op (alu_op 4'b1001).

---
 rtl/alu_mul_seq.sv | 111 +++++++++++
 tb/tb_alu_mul_seq.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_seq.sv
// Multi-cycle execute-stage multiply sequencer: iterative shift-add over WIDTH
// cycles with pipeline stall, one-cycle done pulse and flush/reset abort.
module alu_mul_seq #(
    parameter int unsigned WIDTH  = 32,
    parameter logic [3:0]  MUL_OP = 4'b1001
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic [WIDTH-1:0] mul_result,
    output logic             mul_done,
    output logic             stall
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] acc_sum;
    logic             accept;

    assign accept = ex_valid && (alu_op == MUL_OP) && !flush;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        count_d  = count_q;
        result_d = result_q;
        done_d   = 1'b0;
        stall    = 1'b0;
        acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);

        // Reset is folded in here only so stall drops in the reset cycle.
        if (rst || flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        stall    = 1'b1;
                        mcand_d  = a;
                        mplier_d = b;
                        acc_d    = '0;
                        count_d  = '0;
                        state_d  = BUSY;
                    end
                end
                BUSY: begin
                    stall    = 1'b1;
                    acc_d    = acc_sum;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    count_d  = count_q + CW'(1);
                    if (count_q == LAST_STEP) begin
                        state_d  = DONE;
                        result_d = acc_sum;
                        done_d   = 1'b1;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            count_q  <= count_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign mul_result = result_q;
    assign mul_done   = done_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq: scoreboard of expected products,
// latency/stall-length checks, flush, pass-through, back-to-back and reset.
module tb_alu_mul_seq;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic [3:0]  alu_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic [31:0] mul_result;
    logic        mul_done;
    logic        stall;

    int          tests;
    int          fails;
    int unsigned cyc_cnt;
    logic [31:0] exp_q[$];
    logic [31:0] last_result;

    alu_mul_seq #(
        .WIDTH (32),
        .MUL_OP(4'b1001)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ex_valid  (ex_valid),
        .alu_op    (alu_op),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .mul_result(mul_result),
        .mul_done  (mul_done),
        .stall     (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        ex_valid = 1'b0;
        alu_op   = 4'b0000;
        a        = '0;
        b        = '0;
        flush    = 1'b0;
    endtask

    // Issues one multiply, waits (bounded) for mul_done, checks latency,
    // stall length and the scoreboard result. Returns in the cycle after DONE.
    task automatic run_mul(input logic [31:0] aa, input logic [31:0] bb,
                           input string name, output int unsigned done_at);
        logic [31:0] prod;
        logic [31:0] res_obs;
        logic [31:0] exp_v;
        int          stall_cnt;
        int          done_cyc;
        prod = aa * bb;
        exp_q.push_back(prod);
        ex_valid  = 1'b1;
        alu_op    = 4'b1001;
        a         = aa;
        b         = bb;
        flush     = 1'b0;
        stall_cnt = 0;
        done_cyc  = -1;
        done_at   = 0;
        res_obs   = '0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (mul_done === 1'b1) begin
                done_cyc = c;
                done_at  = cyc_cnt;
                res_obs  = mul_result;
                tests++;
                if (stall !== 1'b0) begin
                    fails++;
                    $display("FAIL %s stall_in_done: got %b want 0", name, stall);
                end
                break;
            end
            if (stall === 1'b1) stall_cnt++;
            next_cycle();
        end
        next_cycle();
        drive_idle();
        tests++;
        if (done_cyc != 33) begin
            fails++;
            $display("FAIL %s done_latency: got %0d want 33", name, done_cyc);
        end
        tests++;
        if (stall_cnt != 33) begin
            fails++;
            $display("FAIL %s stall_cycles: got %0d want 33", name, stall_cnt);
        end
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            if (done_cyc >= 0) begin
                tests++;
                if (res_obs !== exp_v) begin
                    fails++;
                    $display("FAIL %s result: got %h want %h", name, res_obs, exp_v);
                end
                last_result = exp_v;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        ex_valid = 1'b1;
        alu_op   = 4'b1001;
        repeat (3) next_cycle();
        @(negedge clk);
        tests++;
        if (mul_result !== 32'h0 || mul_done !== 1'b0 || stall !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: got res=%h done=%b stall=%b want 0/0/0",
                     mul_result, mul_done, stall);
        end
        next_cycle();
        rst = 1'b0;
        drive_idle();
        last_result = '0;
    endtask

    task automatic test_basic();
        int unsigned t;
        run_mul(32'd3, 32'd5, "basic_3x5", t);
    endtask

    task automatic test_signed();
        int unsigned t;
        run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, "signed_m1xm1", t);
        run_mul(32'hFFFFFFF9, 32'd6, "signed_m7x6", t);
        tests++;
        if (last_result !== 32'hFFFFFFD6) begin
            fails++;
            $display("FAIL signed_m7x6_const: got %h want FFFFFFD6", last_result);
        end
    endtask

    task automatic test_wrap();
        int unsigned t;
        run_mul(32'h00010000, 32'h00010000, "wrap_2p16sq", t);
        run_mul(32'h7FFFFFFF, 32'd2, "wrap_max_x2", t);
    endtask

    task automatic test_random();
        int unsigned t;
        for (int i = 0; i < 4; i++) begin
            run_mul($urandom, $urandom, "random", t);
        end
    endtask

    task automatic test_flush();
        int bad_stall;
        int bad_done;
        bad_stall = 0;
        bad_done  = 0;
        ex_valid = 1'b1;
        alu_op   = 4'b1001;
        a        = 32'd3;
        b        = 32'd5;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (stall !== 1'b1) bad_stall++;
            next_cycle();
        end
        tests++;
        if (bad_stall != 0) begin
            fails++;
            $display("FAIL flush_prestall: got %0d low cycles want 0", bad_stall);
        end
        flush = 1'b1;
        @(negedge clk);
        tests++;
        if (stall !== 1'b0 || mul_done !== 1'b0) begin
            fails++;
            $display("FAIL flush_cycle: got stall=%b done=%b want 0/0", stall, mul_done);
        end
        next_cycle();
        drive_idle();
        @(negedge clk);
        tests++;
        if (stall !== 1'b0) begin
            fails++;
            $display("FAIL flush_after_stall: got %b want 0", stall);
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (mul_done !== 1'b0 || stall !== 1'b0) bad_done++;
        end
        tests++;
        if (bad_done != 0) begin
            fails++;
            $display("FAIL flush_no_done: got %0d bad cycles want 0", bad_done);
        end
        tests++;
        if (mul_result !== last_result) begin
            fails++;
            $display("FAIL flush_result_hold: got %h want %h", mul_result, last_result);
        end
        // Multiply presented together with flush in IDLE must be dropped.
        next_cycle();
        ex_valid = 1'b1;
        alu_op   = 4'b1001;
        a        = 32'd9;
        b        = 32'd9;
        flush    = 1'b1;
        @(negedge clk);
        tests++;
        if (stall !== 1'b0) begin
            fails++;
            $display("FAIL flush_same_cycle_stall: got %b want 0", stall);
        end
        next_cycle();
        drive_idle();
        bad_done = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (mul_done !== 1'b0 || stall !== 1'b0) bad_done++;
        end
        tests++;
        if (bad_done != 0) begin
            fails++;
            $display("FAIL flush_same_cycle_accept: got %0d bad cycles want 0", bad_done);
        end
        next_cycle();
    endtask

    task automatic test_passthrough();
        logic [3:0] ops[3];
        logic       vld[3];
        int         bad;
        ops[0] = 4'b0000; vld[0] = 1'b1;
        ops[1] = 4'b1100; vld[1] = 1'b1;
        ops[2] = 4'b1001; vld[2] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bad      = 0;
            ex_valid = vld[k];
            alu_op   = ops[k];
            a        = 32'd11;
            b        = 32'd13;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                if (stall !== 1'b0 || mul_done !== 1'b0) bad++;
                next_cycle();
            end
            tests++;
            if (bad != 0) begin
                fails++;
                $display("FAIL passthrough op=%b valid=%b: got %0d stalled/done cycles want 0",
                         ops[k], vld[k], bad);
            end
        end
        drive_idle();
        repeat (35) next_cycle();
        @(negedge clk);
        tests++;
        if (mul_done !== 1'b0 || mul_result !== last_result) begin
            fails++;
            $display("FAIL passthrough_hold: got done=%b res=%h want 0/%h",
                     mul_done, mul_result, last_result);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        int unsigned t1;
        int unsigned t2;
        run_mul(32'd2, 32'd3, "b2b_first", t1);
        run_mul(32'd4, 32'd5, "b2b_second", t2);
        tests++;
        if (t2 - t1 != 34) begin
            fails++;
            $display("FAIL b2b_interval: got %0d want 34", t2 - t1);
        end
    endtask

    task automatic test_reset_mid_busy();
        int bad;
        int unsigned t;
        bad      = 0;
        ex_valid = 1'b1;
        alu_op   = 4'b1001;
        a        = 32'd7;
        b        = 32'd9;
        repeat (5) next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        drive_idle();
        @(negedge clk);
        tests++;
        if (mul_result !== 32'h0 || mul_done !== 1'b0 || stall !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_busy: got res=%h done=%b stall=%b want 0/0/0",
                     mul_result, mul_done, stall);
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (mul_done !== 1'b0 || stall !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL reset_mid_busy_quiet: got %0d bad cycles want 0", bad);
        end
        next_cycle();
        run_mul(32'd6, 32'd7, "after_reset", t);
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        cyc_cnt = 0;
        rst     = 1'b1;
        drive_idle();
        test_reset();
        test_basic();
        test_signed();
        test_wrap();
        test_random();
        test_flush();
        test_passthrough();
        test_back_to_back();
        test_reset_mid_busy();
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
